// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - start-triggered SPI SCLK burst generator with sample/shift strobes
module spi_sclk_gen #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [DIV_WIDTH-1:0] div_half_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic [CNT_WIDTH-1:0] nbits_i,
    output logic                 sclk_o,
    output logic                 busy_o,
    output logic                 sample_stb_o,
    output logic                 shift_stb_o,
    output logic                 done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;

    localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]   EDGE_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH:0]   edge_q, edge_d;
    logic [CNT_WIDTH-1:0] n_q, n_d;
    logic                 cpol_q, cpol_d;
    logic                 cpha_q, cpha_d;
    logic                 sclk_q, sclk_d;
    logic                 sample_q, sample_d;
    logic                 shift_q, shift_d;
    logic                 done_q, done_d;

    logic [CNT_WIDTH:0]   edge_nx;
    logic [CNT_WIDTH:0]   two_n;

    assign edge_nx = edge_q + EDGE_ONE;
    assign two_n   = {n_q, 1'b0};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        edge_d   = edge_q;
        n_d      = n_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        sclk_d   = sclk_q;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                sclk_d = cpol_i;
                if (start_i && (nbits_i != '0)) begin
                    div_d   = div_half_i;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    n_d     = nbits_i;
                    cnt_d   = '0;
                    edge_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == div_q) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_nx;
                    // Odd edge count = leading edge, even = trailing edge.
                    if (edge_nx[0]) begin
                        sample_d = ~cpha_q;
                        shift_d  = cpha_q;
                    end else begin
                        sample_d = cpha_q;
                        shift_d  = ~cpha_q && (edge_nx != two_n);
                    end
                    if (edge_nx == two_n) begin
                        state_d = S_TAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_TAIL: begin
                sclk_d = cpol_q;
                if (cnt_q == div_q) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            edge_q   <= '0;
            n_q      <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            n_q      <= n_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            sclk_q   <= sclk_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
        end
    end

    assign sclk_o       = sclk_q;
    assign busy_o       = (state_q != S_IDLE);
    assign sample_stb_o = sample_q;
    assign shift_stb_o  = shift_q;
    assign done_o       = done_q;

endmodule

// File: doc/spi_sclk_gen.md
# spi_sclk_gen

Parametrised SPI serial-clock generator for the Pmod peripheral interfaces. It replaces the fixed-ratio free-running divider with a start-triggered burst generator that has a runtime divisor, runtime CPOL/CPHA and a programmable bit count. It also produces single-cycle sample/shift strobes aligned to SCLK edges. It sits between the transaction controller (which drives chip-select and `start`) and the shift register (which consumes the strobes).

## Interface
Parameters:
- `DIV_WIDTH`, 16: width of the half-period divisor.
- `CNT_WIDTH`, 5: width of `nbits`; the maximum burst is 2^CNT_WIDTH−1 bits.

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request to begin a burst.
- `div_half`  input  DIV_WIDTH  SCLK half-period in `clk` cycles, minus 1.
- `cpol`  input  1  SCLK idle level.
- `cpha`  input  1  0: sample on the leading edge; 1: sample on the trailing edge.
- `nbits`  input  CNT_WIDTH  bits per burst.
- `sclk`  output  1  registered serial clock.
- `busy`  output  1  burst in progress.
- `sample_stb`  output  1  one-cycle pulse: capture MISO.
- `shift_stb`  output  1  one-cycle pulse: advance MOSI.
- `done`  output  1  one-cycle pulse on burst completion.

## Operation
- States: IDLE, RUN, TAIL.
- IDLE:
  - `busy`=0 and strobes are 0.
  - `sclk` loads `cpol` every cycle.
  - If `start`=1 and `nbits`≠0, latch `div_half`→div_q, `cpol`, `cpha` and `nbits`→N. Clear the half-period counter and the edge counter, then go to RUN.
  - If `start`=1 and `nbits`=0, stay in IDLE; no output changes.
- RUN:
  - The half-period counter counts 0..div_q.
  - When the counter equals div_q: toggle `sclk`, reset the counter, increment the edge count e (1..2N).
  - Odd e is a leading edge; even e is a trailing edge.
  - CPHA=0: `sample_stb` on odd edges; `shift_stb` on even edges except e=2N.
  - CPHA=1: `shift_stb` on odd edges; `sample_stb` on even edges.
  - At e=2N go to TAIL. `sclk` is back at the latched cpol at this point.
- TAIL:
  - Count one further half-period (div_q+1 cycles) with `sclk` held at the latched cpol.
  - Then go to IDLE and assert `done` for exactly the first IDLE cycle.
- Inputs `start`, `div_half`, `cpol`, `cpha` and `nbits` are ignored while `busy`=1. Changing them mid-burst has no effect.
- Edge counter width is CNT_WIDTH+1, so 2N never overflows. The half-period counter is DIV_WIDTH bits, and its compare is equality only.

## Timing
- Reset values: `sclk`=0, `busy`=0, `sample_stb`=0, `shift_stb`=0, `done`=0; state IDLE with all counters 0. `rst` overrides `start` in the same cycle.
- Reset mid-burst: on the next edge all outputs take their reset values. No `done` is generated.
- Start latency: `start` sampled at edge T gives `busy`=1 from T+1.
- First SCLK edge: registered at edge T+1+div_q, i.e. div_q+1 cycles after `busy` rises.
- Strobe alignment: each strobe is registered in the same cycle as its `sclk` toggle and is high for 1 cycle.
- SCLK period: 2·(div_q+1) `clk` cycles. div_q=0 gives `clk`/2.
- Busy duration: `busy`=1 for exactly (2N+1)·(div_q+1) cycles.
- Completion: `done` is high in the cycle `busy` first reads 0.
- Back-to-back bursts: a `start` in the `done` cycle is accepted.
- Strobe counts per burst: CPHA=0 gives N `sample_stb` and N−1 `shift_stb`; CPHA=1 gives N of each.

## Test plan
- Reset: hold `rst` 3 cycles with `start`=1 → `sclk`=0, `busy`=0, all strobes 0, `done` never asserts.
- Mode 0, `div_half`=1, `nbits`=8:
  - `sclk` idles 0 and toggles every 2 cycles, giving 16 edges.
  - 8 `sample_stb` on rising edges; 7 `shift_stb` on falling edges.
  - `busy` high for 34 cycles, then 1 `done`.
- Mode 3 (`cpol`=1, `cpha`=1), `div_half`=0, `nbits`=4:
  - `sclk` idles 1.
  - 4 `shift_stb` on falling edges; 4 `sample_stb` on rising edges.
  - `busy` high for 9 cycles.
- Change `div_half` 1→5 and pulse `start` mid-burst → period stays 4 cycles, no restart, single `done`.
- Edge cases:
  - `nbits`=0 with `start` → no `busy`.
  - Reassert `start` in the `done` cycle → second burst begins with `busy`=1 the next cycle.
- Reset asserted at edge 5 of an 8-bit burst → next cycle `busy`=0, `sclk`=0, no `done`, no strobes.
